mp_addsub_seq: RTL



---
 rtl/mp_addsub_pkg.sv | 13 +
 rtl/claAddSubGen.sv | 43 ++++
 rtl/mp_addsub_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mp_addsub_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
//   mp_state_t : sequencer FSM states
//   idx_width  : width of the word index register for a given word count
package mp_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;

  // A single-word configuration still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/claAddSubGen.sv
// M-bit carry-lookahead add/subtract slice.
//   x, y : operands (two's complement)
//   sub  : 0 -> {cout,out} = x + y + cin ; 1 -> {cout,out} = x - y - cin
//   cin  : carry-in (add) or borrow-in (sub)
//   out  : M-bit result
//   cout : carry-out (add) or borrow-out (sub)
//   v    : signed overflow of this slice, judged on its own top bit
//   g, p : bitwise generate / propagate terms
module claAddSubGen #(
  parameter int M = 32
) (
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v,
  output logic [M-1:0] g,
  output logic [M-1:0] p
);

  logic [M-1:0] y_eff;
  logic [M:0]   c;

  // Subtraction is x + ~y + ~borrow; the borrow-out is the inverted carry.
  assign y_eff = y ^ {M{sub}};
  assign g     = x & y_eff;
  assign p     = x ^ y_eff;

  always_comb begin
    c    = '0;
    c[0] = cin ^ sub;
    for (int i = 0; i < M; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign out  = p ^ c[M-1:0];
  assign cout = c[M] ^ sub;
  assign v    = c[M] ^ c[M-1];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer. Processes WORDS*M-bit operands one
// M-bit word per clock (least-significant first) through a single
// claAddSubGen slice, chaining carry/borrow between words.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   in_valid/ready   : request handshake; in_sub, in_cin, in_x, in_y operands
//   out_valid/ready  : result handshake; out_sum, out_cout, out_v results
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int M     = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic                 in_cin,
  input  logic [WORDS*M-1:0]   in_x,
  input  logic [WORDS*M-1:0]   in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORDS*M-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_v
);

  localparam int                W        = WORDS * M;
  localparam int                IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  mp_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [M-1:0]     slice_out;
  logic             slice_cout;
  logic             slice_v;

  // Operand registers shift right each RUN cycle so the current word is
  // always in the low M bits.
  claAddSubGen #(.M(M)) u_slice (
    .x    (x_q[M-1:0]),
    .y    (y_q[M-1:0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .out  (slice_out),
    .cout (slice_cout),
    .v    (slice_v),
    .g    (),
    .p    ()
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          sub_d   = in_sub;
          carry_d = in_cin;  // word 0 takes the request's carry/borrow-in
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*M +: M] = slice_out;
        carry_d = slice_cout;
        x_d     = x_q >> M;
        y_d     = y_q >> M;
        if (idx_q == LAST_IDX) begin
          // Only the top word's overflow describes the full-width operation.
          cout_d  = slice_cout;
          v_d     = slice_v;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  // Operand latches carry no meaning until a request is accepted.
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    y_q   <= y_d;
    sub_q <= sub_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_v     = v_q;

endmodule
